dram_result_reader: RTL and testbench
=====================================

// Module: dram_result_reader
// PURPOSE
//  Post-run readback engine for the multi-core processor. Cores write results into
//  per-core DRAM regions; this block reads those regions after all cores halt.
//  On rising edge of proc_done (AND of all coreS) it sequentially reads every region
//  through the data_mem read port and streams words out on a valid/ready interface
//  (UART/debug sink). Owns the DRAM read port only while busy=1.
// PARAMETERS
//  WIDTH           8    data and address width
//  NUM_REGIONS     8    number of per-core result regions
//  BASE_ADDR       128  first address of region 0
//  REGION_STRIDE   16   address distance between consecutive regions
//  WORDS_PER_CORE  16   words read per region (1..REGION_STRIDE)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  proc_done  in   1      all-cores-halted flag
//  mem_rEn    out  1      DRAM read enable
//  mem_addr   out  WIDTH  DRAM read address
//  mem_data   in   WIDTH  DRAM read data; valid the cycle after mem_rEn
//  out_data   out  WIDTH  streamed result word
//  out_core   out  3      coreID owning out_data
//  out_last   out  1      qualifies final word of the dump
//  out_valid  out  1      out_data/out_core/out_last valid
//  out_ready  in   1      sink accepts word when out_valid && out_ready
//  busy       out  1      dump in progress (DRAM port owned)
//  done       out  1      dump complete; held until proc_done falls
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, counters 0. Reset mid-dump aborts immediately.
//  - FSM: IDLE -> REQ -> WAIT -> HOLD -> (REQ | DONE); DONE -> IDLE when proc_done=0.
//  - IDLE: proc_done rising edge (registered prev value) -> REQ, busy=1. Level-high
//    proc_done at reset release does not count as edge.
//  - REQ: mem_rEn=1 for exactly one cycle, mem_addr=BASE_ADDR+r*REGION_STRIDE+w
//    (r=region idx, w=word idx, WIDTH-bit wrap). mem_rEn=0 in all other states.
//  - WAIT: capture mem_data into out_data register; out_valid=1 next cycle (HOLD).
//  - HOLD: out_data/out_core/out_last stable while out_valid && !out_ready.
//    On accept: w++; w==WORDS_PER_CORE -> w=0, r++. After final word -> DONE, else REQ.
//  - Per-word latency with out_ready=1: 3 cycles (REQ,WAIT,HOLD); full dump
//    3*NUM_REGIONS*WORDS_PER_CORE cycles.
//  - out_core = coreID lookup by region index r: {0,7,3,4,1,6,2,5} for r=0..7.
//  - out_last=1 only with r==NUM_REGIONS-1 && w==WORDS_PER_CORE-1.
//  - DONE: busy=0, done=1, out_valid=0. proc_done fall -> IDLE, done=0;
//    next rising edge starts a fresh dump.
//  - proc_done falling mid-dump: ignored; dump completes, then DONE->IDLE at once.
//  - out_ready asserted while out_valid=0: no effect.
// CONFIGURATION
//  SKIP_ZERO_EN defined: in WAIT, a captured word equal to 0 is not presented;
//    FSM advances w/r directly and returns to REQ (2 cycles per skipped word).
//    Final word of the dump is never skipped, so out_last always appears once.
//  SKIP_ZERO_EN undefined: every word presented, zeros included.
// TESTING
//  1. DRAM preloaded addr a = a^8'h5A; pulse proc_done, out_ready=1 -> 128 words,
//     first 128^5A=8'hDA core0, word 17 from addr 145 core7; out_last on addr 255 only.
//  2. out_ready held 0 for 10 cycles on word 3 -> out_data/out_core stable,
//     mem_rEn stays 0, no word lost or duplicated after release.
//  3. rst asserted during region 4 -> all outputs 0 same cycle; proc_done still high
//     after release -> no dump until proc_done falls and rises again.
//  4. Dump finishes -> done=1, busy=0; proc_done 1->0 -> done=0; 0->1 -> second
//     identical 128-word dump.
//  5. SKIP_ZERO_EN, region 2 all zero, addr 255 = 0 -> 112 words emitted, no core3
//     words, final word 8'h00 with out_last=1.

Source files
------------

// File: rtl/dram_result_reader_if.sv
// Bus bundle for dram_result_reader: DRAM read port, result stream and status.
// master = the reader engine, slave = DRAM model / stream sink / sequencer.
interface dram_result_reader_if #(
    parameter int WIDTH = 8
);
    logic             proc_done;
    logic             mem_rEn;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_core;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    modport master (
        input  proc_done, mem_data, out_ready,
        output mem_rEn, mem_addr, out_data, out_core, out_last, out_valid, busy, done
    );

    modport slave (
        output proc_done, mem_data, out_ready,
        input  mem_rEn, mem_addr, out_data, out_core, out_last, out_valid, busy, done
    );
endinterface

// File: rtl/dram_result_reader.sv
// Post-run DRAM result dump: reads every per-core region and streams it out.
// Optional macro SKIP_ZERO_EN drops zero words (except the final one) from the stream.
module dram_result_reader #(
    parameter int WIDTH          = 8,
    parameter int NUM_REGIONS    = 8,
    parameter int BASE_ADDR      = 128,
    parameter int REGION_STRIDE  = 16,
    parameter int WORDS_PER_CORE = 16
) (
    input logic clk,
    input logic rst,
    dram_result_reader_if.master bus
);
    localparam int RW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int WW = (WORDS_PER_CORE > 1) ? $clog2(WORDS_PER_CORE) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(NUM_REGIONS - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WORDS_PER_CORE - 1);
`ifdef SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;

    state_t        state;
    logic [RW-1:0] r_idx;
    logic [WW-1:0] w_idx;
    logic          pd_prev;
    logic          is_last;
    logic [RW-1:0] r_nxt;
    logic [WW-1:0] w_nxt;

    function automatic logic [WIDTH-1:0] addr_of(input logic [RW-1:0] r, input logic [WW-1:0] w);
        int a;
        a = BASE_ADDR + int'(r) * REGION_STRIDE + int'(w);
        return a[WIDTH-1:0];
    endfunction

    // Region index to owning core: cores are not laid out in DRAM in ID order.
    function automatic logic [2:0] core_of(input logic [RW-1:0] r);
        case (int'(r))
            0:       return 3'd0;
            1:       return 3'd7;
            2:       return 3'd3;
            3:       return 3'd4;
            4:       return 3'd1;
            5:       return 3'd6;
            6:       return 3'd2;
            7:       return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    always_comb begin
        is_last = (r_idx == R_LAST) && (w_idx == W_LAST);
        w_nxt   = (w_idx == W_LAST) ? '0 : w_idx + 1'b1;
        r_nxt   = (w_idx == W_LAST) ? r_idx + 1'b1 : r_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            r_idx         <= '0;
            w_idx         <= '0;
            pd_prev       <= 1'b1;  // a level already high at release is not an edge
            bus.mem_rEn   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_core  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            pd_prev <= bus.proc_done;
            case (state)
                IDLE: begin
                    if (bus.proc_done && !pd_prev) begin
                        state        <= REQ;
                        r_idx        <= '0;
                        w_idx        <= '0;
                        bus.busy     <= 1'b1;
                        bus.mem_rEn  <= 1'b1;
                        bus.mem_addr <= addr_of('0, '0);
                    end
                end
                REQ: begin
                    bus.mem_rEn <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (SKIP_ZERO && (bus.mem_data == '0) && !is_last) begin
                        r_idx        <= r_nxt;
                        w_idx        <= w_nxt;
                        bus.mem_rEn  <= 1'b1;
                        bus.mem_addr <= addr_of(r_nxt, w_nxt);
                        state        <= REQ;
                    end else begin
                        bus.out_data  <= bus.mem_data;
                        bus.out_core  <= core_of(r_idx);
                        bus.out_last  <= is_last;
                        bus.out_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (is_last) begin
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            r_idx        <= r_nxt;
                            w_idx        <= w_nxt;
                            bus.mem_rEn  <= 1'b1;
                            bus.mem_addr <= addr_of(r_nxt, w_nxt);
                            state        <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (!bus.proc_done) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dram_result_reader.sv
// Scoreboard bench for dram_result_reader: stimulus pushes expected words, a monitor pops them.
module tb_dram_result_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_result_reader_if #(.WIDTH(8)) bus ();
    dram_result_reader dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] core;
        logic       last;
    } item_t;

    item_t      exp_q[$];
    logic [7:0] mem [256];
    logic [2:0] cmap [8] = '{3'd0, 3'd7, 3'd3, 3'd4, 3'd1, 3'd6, 3'd2, 3'd5};
    logic [7:0] log_data [256];
    logic [2:0] log_core [256];
    logic       log_last [256];
    int passed = 0;
    int total  = 0;
    int acc_cnt, last_cnt, core3_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        else passed++;
    endtask

    always @(posedge clk) if (bus.mem_rEn) bus.mem_data <= mem[bus.mem_addr];

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {21'd0, bus.out_data, bus.out_core}, 32'hFFFF_FFFF);
            end else begin
                item_t e;
                e = exp_q.pop_front();
                chk("sb_data", bus.out_data, e.data);
                chk("sb_core", bus.out_core, e.core);
                chk("sb_last", bus.out_last, e.last);
            end
            if (acc_cnt < 256) begin
                log_data[acc_cnt] = bus.out_data;
                log_core[acc_cnt] = bus.out_core;
                log_last[acc_cnt] = bus.out_last;
            end
            acc_cnt++;
            if (bus.out_last) last_cnt++;
            if (bus.out_core == 3'd3) core3_cnt++;
        end
    end

    task automatic push_dump();
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 16; w++) begin
                item_t e;
                int a;
                a = 128 + 16 * r + w;
                e.data = mem[a];
                e.core = cmap[r];
                e.last = (r == 7 && w == 15);
`ifdef SKIP_ZERO_EN
                if (e.data == 8'h00 && !e.last) continue;
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_dump();
        push_dump();
        acc_cnt   = 0;
        last_cnt  = 0;
        core3_cnt = 0;
        @(posedge clk); #1;
        bus.proc_done = 1'b1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_reached", bus.done, 1'b1);
    endtask

    task automatic drop_proc_done();
        @(posedge clk); #1;
        bus.proc_done = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, n, busy_seen;
        logic [7:0] d0;
        logic [2:0] c0;
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
        bus.proc_done = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_ren", bus.mem_rEn, 1'b0);
        chk("rst_outs", {bus.out_data, bus.out_core, bus.out_last, bus.mem_addr}, 32'd0);
        rst = 1'b0;

        // Full dump with the sink always ready
        bus.out_ready = 1'b1;
        start_dump();
        wait_done(cyc);
        chk("dump1_cycles", cyc, 385);
        chk("dump1_busy", bus.busy, 1'b0);
        chk("dump1_count", acc_cnt, 128);
        chk("dump1_qempty", exp_q.size(), 0);
        chk("word0_data", log_data[0], 8'hDA);
        chk("word0_core", log_core[0], 3'd0);
        chk("word17_data", log_data[17], 8'hCB);
        chk("word17_core", log_core[17], 3'd7);
        chk("word127_data", log_data[127], 8'hA5);
        chk("word127_last", log_last[127], 1'b1);
        chk("last_once", last_cnt, 1);

        // done holds while proc_done high, clears on its fall, new edge gives a second dump
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", bus.done, 1'b1);
        bus.proc_done = 1'b0;
        @(posedge clk); #1;
        chk("done_cleared", bus.done, 1'b0);
        start_dump();
        wait_done(cyc);
        chk("dump2_cycles", cyc, 385);
        chk("dump2_count", acc_cnt, 128);
        chk("dump2_qempty", exp_q.size(), 0);

        // Backpressure: word 3 stalled for 10 cycles
        drop_proc_done();
        bus.out_ready = 1'b0;
        start_dump();
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("stall_valid_seen", bus.out_valid, 1'b1);
            if (k == 3) begin
                d0 = bus.out_data;
                c0 = bus.out_core;
                chk("stall_word3", d0, 8'h83 ^ 8'h5A);
                repeat (10) begin
                    @(posedge clk); #1;
                    chk("stall_data", bus.out_data, d0);
                    chk("stall_core", bus.out_core, c0);
                    chk("stall_valid", bus.out_valid, 1'b1);
                    chk("stall_ren", bus.mem_rEn, 1'b0);
                end
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            if (k < 3) bus.out_ready = 1'b0;
        end
        wait_done(cyc);
        chk("stall_count", acc_cnt, 128);
        chk("stall_qempty", exp_q.size(), 0);

        // Reset during region 4, proc_done left high
        drop_proc_done();
        start_dump();
        n = 0;
        while (acc_cnt < 70 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_region4", acc_cnt >= 70, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_valid", bus.out_valid, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_ren", bus.mem_rEn, 1'b0);
        chk("abort_outs", {bus.out_data, bus.out_core, bus.out_last, bus.mem_addr}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        busy_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.busy || bus.mem_rEn || bus.out_valid) busy_seen++;
        end
        chk("no_dump_on_level", busy_seen, 0);
        drop_proc_done();
        start_dump();
        wait_done(cyc);
        chk("post_rst_count", acc_cnt, 128);
        chk("post_rst_qempty", exp_q.size(), 0);

`ifdef SKIP_ZERO_EN
        // Region 2 (core 3) and the final word zeroed
        drop_proc_done();
        for (int a = 160; a < 176; a++) mem[a] = 8'h00;
        mem[255] = 8'h00;
        start_dump();
        wait_done(cyc);
        chk("skip_cycles", cyc, 369);
        chk("skip_count", acc_cnt, 112);
        chk("skip_core3", core3_cnt, 0);
        chk("skip_final_data", log_data[111], 8'h00);
        chk("skip_final_last", log_last[111], 1'b1);
        chk("skip_qempty", exp_q.size(), 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
